// File: rtl/grad_bram_ctrl.sv
// Gradient waveform sequencer: AXI4-Lite register/BRAM slave that replays stored words
// to the DAC serialisers at a programmable interval, with direct-write and ADC readback.
module grad_bram_ctrl #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [15:0]                       offset_i,
    input  logic                              data_enb_i,
    input  logic                              serial_busy_i,
    input  logic                              data_lost_i,
    input  logic [15:0]                       adc_i,
    output logic [31:0]                       data_o,
    output logic [3:0]                        valid_o,
    output logic [5:0]                        spi_clk_div_o,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int unsigned MEM_AW    = 13;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam int unsigned TMR_W     = 17;
    localparam int unsigned HOLD_W    = 3;
    localparam logic [15:0] REG0_RST  = 16'd303;

    // Register-file and AXI state
    logic [15:0]       reg0_q, reg0_d;
    logic [31:0]       reg1_q, reg1_d;
    logic [31:0]       reg2_q, reg2_d;
    logic [31:0]       reg3_q, reg3_d;
    logic              aw_ready_q, aw_ready_d;
    logic              bvalid_q, bvalid_d;
    logic              ar_ready_q, ar_ready_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;

    // Playback state
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        valid_q, valid_d;
    logic              data_lost_q, data_lost_d;
    logic              busy_drop_q, busy_drop_d;

    logic [31:0]       mem [MEM_DEPTH];
    logic [31:0]       rd_word_q;

    logic              wr_fire, rd_fire;
    logic              w_in_mem, w_in_regs, r_in_regs;
    logic [2:0]        w_idx, r_idx;
    logic [MEM_AW-1:0] w_mem_idx;
    logic              wr_reg0, wr_reg1, wr_reg2, wr_reg3, wr_mem;
    logic              stat_clr;
    logic              play_evt;
    logic              busy_set;
    logic [31:0]       status_c;
    logic [31:0]       rd_mux;

    // Write/read address decode; the AXI master holds addresses stable until the handshake
    assign wr_fire   = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire   = ar_ready_q & S_AXI_ARVALID;
    assign w_in_mem  = S_AXI_AWADDR[15];
    assign w_in_regs = ~S_AXI_AWADDR[15] & (S_AXI_AWADDR[14:5] == 10'd0);
    assign r_in_regs = ~S_AXI_ARADDR[15] & (S_AXI_ARADDR[14:5] == 10'd0);
    assign w_idx     = S_AXI_AWADDR[4:2];
    assign r_idx     = S_AXI_ARADDR[4:2];
    assign w_mem_idx = S_AXI_AWADDR[14:2];

    assign wr_reg0   = wr_fire & w_in_regs & (w_idx == 3'd0);
    assign wr_reg1   = wr_fire & w_in_regs & (w_idx == 3'd1);
    assign wr_reg2   = wr_fire & w_in_regs & (w_idx == 3'd2);
    assign wr_reg3   = wr_fire & w_in_regs & (w_idx == 3'd3);
    assign wr_mem    = wr_fire & w_in_mem;
    assign stat_clr  = rd_fire & r_in_regs & (r_idx == 3'd4);

    assign status_c  = {14'd0, busy_drop_q, data_lost_q, 3'd0, addr_q};

    // Interval expiry; >= lets a lowered REG0 fire the pending output immediately
    assign play_evt  = data_enb_i & (timer_q >= (TMR_W'(reg0_q) + TMR_W'(3)));

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], offset_i[15:13]};

    always_comb begin
        rd_mux = 32'd0;
        if (r_in_regs) begin
            case (r_idx)
                3'd0:    rd_mux = {16'd0, reg0_q};
                3'd1:    rd_mux = reg1_q;
                3'd2:    rd_mux = reg2_q;
                3'd3:    rd_mux = reg3_q;
                3'd4:    rd_mux = status_c;
                3'd5:    rd_mux = {16'd0, adc_i};
                default: rd_mux = 32'd0;
            endcase
        end
    end

    // Next-state logic for AXI channels, registers and playback
    always_comb begin
        reg0_d      = reg0_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        reg3_d      = reg3_q;
        aw_ready_d  = 1'b0;
        bvalid_d    = bvalid_q;
        ar_ready_d  = 1'b0;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        timer_d     = timer_q;
        hold_d      = hold_q;
        data_d      = data_q;
        valid_d     = 4'd0;
        busy_set    = 1'b0;
        data_lost_d = data_lost_q;
        busy_drop_d = busy_drop_q;

        aw_ready_d = ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        ar_ready_d = ~ar_ready_q & S_AXI_ARVALID & ~rvalid_q;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        if (wr_reg0) reg0_d = S_AXI_WDATA[15:0];
        if (wr_reg1) reg1_d = S_AXI_WDATA;
        if (wr_reg2) reg2_d = S_AXI_WDATA;
        if (wr_reg3) reg3_d = S_AXI_WDATA;

        if (!data_enb_i) begin
            addr_d  = offset_i[MEM_AW-1:0];
            timer_d = '0;
            hold_d  = '0;
        end else if (play_evt && !wr_reg3) begin
            timer_d = '0;
            if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else begin
                data_d = rd_word_q;
                hold_d = rd_word_q[29:27];
                addr_d = addr_q + MEM_AW'(1);
                if (serial_busy_i) begin
                    busy_set = 1'b1;
                end else begin
                    valid_d = reg2_q[3:0];
                end
            end
        end else if (!play_evt) begin
            timer_d = timer_q + TMR_W'(1);
        end

        // Direct word wins; a coincident playback event stays armed and fires next cycle
        if (wr_reg3) begin
            data_d  = S_AXI_WDATA;
            valid_d = reg2_q[3:0];
        end

        data_lost_d = (data_lost_q & ~stat_clr) | data_lost_i;
        busy_drop_d = (busy_drop_q & ~stat_clr) | busy_set;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            reg0_q      <= REG0_RST;
            reg1_q      <= 32'd0;
            reg2_q      <= 32'd0;
            reg3_q      <= 32'd0;
            aw_ready_q  <= 1'b0;
            bvalid_q    <= 1'b0;
            ar_ready_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            addr_q      <= offset_i[MEM_AW-1:0];
            timer_q     <= '0;
            hold_q      <= '0;
            data_q      <= 32'd0;
            valid_q     <= 4'd0;
            data_lost_q <= 1'b0;
            busy_drop_q <= 1'b0;
        end else begin
            reg0_q      <= reg0_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            reg3_q      <= reg3_d;
            aw_ready_q  <= aw_ready_d;
            bvalid_q    <= bvalid_d;
            ar_ready_q  <= ar_ready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            timer_q     <= timer_d;
            hold_q      <= hold_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            data_lost_q <= data_lost_d;
            busy_drop_q <= busy_drop_d;
        end
    end

    // Waveform BRAM: one write port from AXI, registered read tracking the playback address
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_mem) begin
            mem[w_mem_idx] <= S_AXI_WDATA;
        end
        rd_word_q <= mem[addr_q];
    end

    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign spi_clk_div_o = reg1_q[5:0];
    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_grad_bram_ctrl.sv
// Self-checking bench for grad_bram_ctrl: directed register/status steps plus randomized
// playback compared against a timing/hold model derived from the interval and hold rules.
module tb_grad_bram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] offset;
    logic        enb, busy, lost;
    logic [15:0] adc;
    logic [31:0] data_o;
    logic [3:0]  valid_o;
    logic [5:0]  spi_div;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    // Reference state: what the bench has written
    logic [31:0] model_mem [8192];
    logic [15:0] m_reg0;
    logic [31:0] m_reg2;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic [3:0]  valid;
    } ev_t;
    ev_t evq[$];
    logic [31:0] prev_data = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grad_bram_ctrl dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .offset_i(offset), .data_enb_i(enb), .serial_busy_i(busy), .data_lost_i(lost),
        .adc_i(adc), .data_o(data_o), .valid_o(valid_o), .spi_clk_div_o(spi_div),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    // Output monitor: every valid pulse or data change, stamped with the edge count
    always @(negedge clk) begin
        if (valid_o != 4'd0 || data_o !== prev_data) begin
            evq.push_back('{cyc, data_o, valid_o});
        end
        prev_data = data_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 16) begin @(posedge clk); #1; n++; end
        check("aw_handshake", 32'(awready & wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 16) begin @(posedge clk); #1; n++; end
        check("b_valid", {29'd0, bresp, bvalid}, 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 16) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 16) begin @(posedge clk); #1; n++; end
        check("r_valid", {29'd0, rresp, rvalid}, 32'd1);
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic bram_write(input int unsigned idx, input logic [31:0] d);
        axi_write(16'(32'h8000 + idx * 4), d);
        model_mem[idx] = d;
    endtask

    task automatic set_reg0(input logic [15:0] v);
        axi_write(16'h0000, {16'd0, v});
        m_reg0 = v;
    endtask

    task automatic start_play(input logic [15:0] off, output int unsigned c0);
        offset = off;
        @(posedge clk); #1;
        enb = 1'b1;
        c0 = cyc;
        evq.delete();
    endtask

    task automatic stop_play();
        @(posedge clk); #1;
        enb = 1'b0;
    endtask

    task automatic wait_data(input string tag, input logic [31:0] v, input int limit);
        int n = 0;
        while (data_o !== v && n < limit) begin @(negedge clk); n++; end
        check(tag, data_o, v);
    endtask

    // Expected output k lands one period after the previous one, stretched by its hold count
    task automatic expect_words(input int unsigned c0, input int unsigned off, input int n,
                                input string tg);
        int unsigned t, a, p, h;
        int unsigned et[$];
        logic [31:0] ed[$];
        p = 32'(m_reg0) + 4; t = c0; a = off; h = 0;
        for (int j = 0; j < n; j++) begin
            t = t + p * (h + 1);
            et.push_back(t);
            ed.push_back(model_mem[a]);
            h = 32'(model_mem[a][29:27]);
            a = (a + 1) % 8192;
        end
        while (cyc < t + 2) @(negedge clk);
        check({tg, "_count"}, 32'(evq.size()), 32'(n));
        for (int j = 0; j < n && j < evq.size(); j++) begin
            check($sformatf("%s_cyc%0d", tg, j), evq[j].cyc, et[j]);
            check($sformatf("%s_data%0d", tg, j), evq[j].data, ed[j]);
            check($sformatf("%s_valid%0d", tg, j), 32'(evq[j].valid), 32'(m_reg2[3:0]));
        end
    endtask

    initial begin
        int unsigned c0;
        rst = 1'b1; offset = 16'd0; enb = 1'b0; busy = 1'b0; lost = 1'b0; adc = 16'hBEEF;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = 4'hF;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        m_reg0 = 16'd303; m_reg2 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_data", data_o, 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_spi", 32'(spi_div), 32'd0);
        check("rst_axi", {28'd0, awready, bvalid, arready, rvalid}, 32'd0);

        // Register file, direct word, readback
        axi_write(16'h0004, 32'd30);
        axi_write(16'h0008, 32'hCAFEBEEF);
        m_reg2 = 32'hCAFEBEEF;
        evq.delete();
        axi_write(16'h000C, 32'hABCD0123);
        repeat (2) @(negedge clk);
        check("reg3_events", 32'(evq.size()), 32'd1);
        if (evq.size() > 0) begin
            check("reg3_data", evq[0].data, 32'hABCD0123);
            check("reg3_valid", 32'(evq[0].valid), 32'hF);
        end
        check("spi_div", 32'(spi_div), 32'd30);
        axi_write(16'h0018, 32'h1234);
        axi_write(16'h0010, 32'hFFFF_FFFF);
        read_check("rd_reg0", 16'h0000, 32'd303);
        read_check("rd_reg1", 16'h0004, 32'd30);
        read_check("rd_reg2", 16'h0008, 32'hCAFEBEEF);
        read_check("rd_reg3", 16'h000C, 32'hABCD0123);
        read_check("rd_status", 16'h0010, 32'd0);
        read_check("rd_adc", 16'h0014, 32'h0000BEEF);
        read_check("rd_unmapped", 16'h0018, 32'd0);

        // Ramp content and basic playback at default and minimum interval
        for (int k = 0; k < 16; k++) bram_write(k, 32'(k));
        read_check("rd_bram", 16'h8004, 32'd0);
        repeat (20) @(negedge clk);
        start_play(16'd0, c0);
        expect_words(c0, 0, 4, "pb303");
        stop_play();
        set_reg0(16'd0);
        start_play(16'd0, c0);
        expect_words(c0, 0, 6, "pb0");
        stop_play();
        set_reg0(16'd303);

        // Offset playback, offset ignored while enabled, status flags
        start_play(16'd10, c0);
        offset = 16'd100;
        wait_data("w10", 32'd10, 400);
        check("w10_valid", 32'(valid_o), 32'hF);
        read_check("st_after10", 16'h0010, 32'h0000_000B);
        @(negedge clk) lost = 1'b1;
        @(negedge clk) lost = 1'b0;
        read_check("st_lost", 16'h0010, 32'h0001_000B);
        read_check("st_lost_clr", 16'h0010, 32'h0000_000B);
        wait_data("w13", 32'd13, 1200);
        busy = 1'b1;
        wait_data("w14", 32'd14, 400);
        check("w14_dropped", 32'(valid_o), 32'd0);
        busy = 1'b0;
        wait_data("w15", 32'd15, 400);
        check("w15_valid", 32'(valid_o), 32'hF);
        read_check("st_busy", 16'h0010, 32'h0002_0010);
        read_check("st_busy_clr", 16'h0010, 32'h0000_0010);
        stop_play();

        // Hold counts
        for (int k = 0; k < 10; k++) bram_write(8000 + k, (32'(k & 7) << 27) | 32'(k));
        start_play(16'd8000, c0);
        expect_words(c0, 8000, 10, "hold");
        stop_play();

        // Randomized interval, mask, offset (first run wraps past 8191) and content
        for (int it = 0; it < 3; it++) begin
            int unsigned off;
            logic [31:0] r2;
            off = (it == 0) ? 32'd8189 : $urandom_range(0, 8191);
            set_reg0(16'($urandom_range(0, 12)));
            r2 = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(1, 15));
            axi_write(16'h0008, r2);
            m_reg2 = r2;
            for (int k = 0; k < 8; k++) bram_write((off + k) % 8192, $urandom);
            start_play(16'(off), c0);
            expect_words(c0, off, 8, $sformatf("rnd%0d", it));
            stop_play();
        end

        // Reset mid-playback with enable held high
        set_reg0(16'd5);
        start_play(16'd3, c0);
        repeat (30) @(negedge clk);
        lost = 1'b1;
        @(negedge clk) lost = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        c0 = cyc;
        m_reg0 = 16'd303; m_reg2 = 32'd0;
        check("mid_rst_data", data_o, 32'd0);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        @(posedge clk); #1 evq.delete();
        read_check("mid_rst_reg0", 16'h0000, 32'd303);
        read_check("mid_rst_status", 16'h0010, 32'h0000_0003);
        expect_words(c0, 3, 3, "rstpb");
        stop_play();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
